// File: rtl/traffic_light_monitor.sv
// Lamp-bus conflict/sequence monitor: decodes the controller's 12-bit lights pattern into a phase,
// checks successor order and dwell time, latches the first fault and forces an all-red flash.
module traffic_light_monitor #(
  parameter int unsigned DWELL_S0   = 64,
  parameter int unsigned DWELL_S1   = 4,
  parameter int unsigned DWELL_S2   = 16,
  parameter int unsigned DWELL_S3   = 4,
  parameter int unsigned DWELL_S4   = 20,
  parameter int unsigned DWELL_S5   = 4,
  parameter int unsigned DWELL_S6   = 4,
  parameter int unsigned TOL        = 0,
  parameter int unsigned FLASH_HALF = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] lights,
  input  logic        fault_clr,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [2:0]  fault_state,
  output logic [2:0]  phase,
  output logic [11:0] safe_lights
);

  localparam logic [11:0] ALL_RED  = 12'h111;
  localparam logic [2:0]  PH_NONE  = 3'b111;
  localparam int unsigned FW       = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  function automatic bit dwell_ok(input int unsigned d);
    return (d >= TOL + 1) && (d + TOL <= 254);
  endfunction

  localparam bit DWELL_CFG_OK = dwell_ok(DWELL_S0) && dwell_ok(DWELL_S1) && dwell_ok(DWELL_S2) &&
                                dwell_ok(DWELL_S3) && dwell_ok(DWELL_S4) && dwell_ok(DWELL_S5) &&
                                dwell_ok(DWELL_S6) && (FLASH_HALF >= 1);

  if (!DWELL_CFG_OK) begin : g_bad_cfg
    $error("traffic_light_monitor: each DWELL_Sx must satisfy DWELL-TOL >= 1 and DWELL+TOL <= 254");
  end

  typedef enum logic [1:0] {
    ST_ARM,
    ST_MONITOR,
    ST_FAULT
  } state_e;

  typedef enum logic [2:0] {
    FC_NONE    = 3'd0,
    FC_ILLEGAL = 3'd1,
    FC_SEQ     = 3'd2,
    FC_SHORT   = 3'd3,
    FC_STUCK   = 3'd4
  } fault_code_e;

  function automatic logic [11:0] pat_of(input logic [2:0] p);
    case (p)
      3'd0:    return 12'hA38;
      3'd1:    return 12'h458;
      3'd2:    return 12'h893;
      3'd3:    return 12'h854;
      3'd4:    return 12'h38A;
      3'd5:    return 12'h886;
      3'd6:    return 12'h648;
      default: return ALL_RED;
    endcase
  endfunction

  function automatic logic [8:0] dwell_of(input logic [2:0] p);
    case (p)
      3'd0:    return 9'(DWELL_S0);
      3'd1:    return 9'(DWELL_S1);
      3'd2:    return 9'(DWELL_S2);
      3'd3:    return 9'(DWELL_S3);
      3'd4:    return 9'(DWELL_S4);
      3'd5:    return 9'(DWELL_S5);
      3'd6:    return 9'(DWELL_S6);
      default: return 9'd0;
    endcase
  endfunction

  function automatic logic succ_ok(input logic [2:0] from, input logic [2:0] to);
    case (from)
      3'd0:    return (to == 3'd1) || (to == 3'd6);
      3'd1:    return to == 3'd2;
      3'd2:    return to == 3'd3;
      3'd3:    return to == 3'd4;
      3'd4:    return to == 3'd5;
      3'd5:    return to == 3'd0;
      3'd6:    return to == 3'd4;
      default: return 1'b0;
    endcase
  endfunction

  state_e      state_q, state_d;
  fault_code_e code_q, code_d, code_n;
  logic [2:0]  phase_q, phase_d;
  logic [2:0]  fstate_q, fstate_d;
  logic [7:0]  dwell_q, dwell_d, dwell_inc;
  logic        first_q, first_d;
  logic        fault_q, fault_d;
  logic [11:0] safe_q, safe_d;
  logic [FW-1:0] flash_q, flash_d;
  logic        dec_legal;
  logic [2:0]  dec_ph;
  logic [8:0]  dwell_hi, dwell_lo;

  always_comb begin
    dec_legal = 1'b1;
    dec_ph    = 3'd0;
    case (lights)
      12'hA38: dec_ph = 3'd0;
      12'h458: dec_ph = 3'd1;
      12'h893: dec_ph = 3'd2;
      12'h854: dec_ph = 3'd3;
      12'h38A: dec_ph = 3'd4;
      12'h886: dec_ph = 3'd5;
      12'h648: dec_ph = 3'd6;
      default: dec_legal = 1'b0;
    endcase
  end

  assign dwell_hi  = dwell_of(phase_q) + 9'(TOL);
  assign dwell_lo  = dwell_of(phase_q) - 9'(TOL);
  assign dwell_inc = (dwell_q == 8'hFF) ? dwell_q : dwell_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    code_n   = FC_NONE;
    phase_d  = phase_q;
    fstate_d = fstate_q;
    dwell_d  = dwell_q;
    first_d  = first_q;
    fault_d  = fault_q;
    safe_d   = safe_q;
    flash_d  = flash_q;

    case (state_q)
      ST_ARM: begin
        safe_d = lights;
        if (dec_legal) begin
          state_d = ST_MONITOR;
          phase_d = dec_ph;
          dwell_d = 8'd1;
          first_d = 1'b1;
        end
      end

      ST_MONITOR: begin
        safe_d = lights;
        if (lights == pat_of(phase_q)) begin
          dwell_d = dwell_inc;
          if ({1'b0, dwell_inc} > dwell_hi) code_n = FC_STUCK;
        end else if (!dec_legal) begin
          code_n = FC_ILLEGAL;
        end else if (!succ_ok(phase_q, dec_ph)) begin
          code_n = FC_SEQ;
        end else if (({1'b0, dwell_q} < dwell_lo) && !first_q) begin
          code_n = FC_SHORT;
        end else begin
          phase_d = dec_ph;
          dwell_d = 8'd1;
          first_d = 1'b0;
        end
        // fault_clr is ignored here, so a same-cycle violation always latches
        if (code_n != FC_NONE) begin
          state_d  = ST_FAULT;
          fault_d  = 1'b1;
          code_d   = code_n;
          fstate_d = phase_q;
          safe_d   = ALL_RED;
          flash_d  = '0;
        end
      end

      ST_FAULT: begin
        if (fault_clr) begin
          state_d = ST_ARM;
          fault_d = 1'b0;
          code_d  = FC_NONE;
          phase_d = PH_NONE;
          flash_d = '0;
          safe_d  = lights;
        end else if (flash_q == FW'(FLASH_HALF - 1)) begin
          flash_d = '0;
          safe_d  = (safe_q == '0) ? ALL_RED : '0;
        end else begin
          flash_d = flash_q + FW'(1);
        end
      end

      default: state_d = ST_ARM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_ARM;
      code_q   <= FC_NONE;
      phase_q  <= PH_NONE;
      fstate_q <= '0;
      dwell_q  <= '0;
      first_q  <= 1'b0;
      fault_q  <= 1'b0;
      safe_q   <= ALL_RED;
      flash_q  <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      phase_q  <= phase_d;
      fstate_q <= fstate_d;
      dwell_q  <= dwell_d;
      first_q  <= first_d;
      fault_q  <= fault_d;
      safe_q   <= safe_d;
      flash_q  <= flash_d;
    end
  end

  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign fault_state = fstate_q;
  assign phase       = phase_q;
  assign safe_lights = safe_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: a cycle-level reference model built from the phase
// table is compared against every DUT output each cycle, plus hand-computed literal checks.
module tb_traffic_light_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] lights;
  logic        fault_clr;
  logic        fault;
  logic [2:0]  fault_code;
  logic [2:0]  fault_state;
  logic [2:0]  phase;
  logic [11:0] safe_lights;

  int n_checks = 0;
  int n_errors = 0;

  traffic_light_monitor #(
    .DWELL_S0(64), .DWELL_S1(4), .DWELL_S2(16), .DWELL_S3(4),
    .DWELL_S4(20), .DWELL_S5(4), .DWELL_S6(4), .TOL(0), .FLASH_HALF(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .lights(lights),
    .fault_clr(fault_clr),
    .fault(fault),
    .fault_code(fault_code),
    .fault_state(fault_state),
    .phase(phase),
    .safe_lights(safe_lights)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: phase table, dwell limits and successor lists (-1 = no second successor)
  int PAT [7] = '{'hA38, 'h458, 'h893, 'h854, 'h38A, 'h886, 'h648};
  int DW  [7] = '{64, 4, 16, 4, 20, 4, 4};
  int NXA [7] = '{1, 2, 3, 4, 5, 0, 4};
  int NXB [7] = '{6, -1, -1, -1, -1, -1, -1};
  localparam int TOL_M = 0;
  localparam int HALF  = 8;

  int m_mode;   // 0 arm, 1 monitor, 2 fault
  int m_ph, m_cnt, m_first, m_fault, m_code, m_fst, m_safe, m_age;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_ph = 7; m_cnt = 0; m_first = 0;
      m_fault = 0; m_code = 0; m_fst = 0; m_safe = 'h111; m_age = 0;
    end else begin
      int idx;
      int l;
      int code;
      l = int'(lights);
      idx = -1;
      for (int i = 0; i < 7; i++) if (PAT[i] == l) idx = i;
      if (m_mode == 0) begin
        m_safe = l;
        if (idx >= 0) begin
          m_mode = 1; m_ph = idx; m_cnt = 1; m_first = 1;
        end
      end else if (m_mode == 1) begin
        code = 0;
        if (l == PAT[m_ph]) begin
          m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
          if (m_cnt > DW[m_ph] + TOL_M) code = 4;
        end else if (idx < 0) code = 1;
        else if (idx != NXA[m_ph] && idx != NXB[m_ph]) code = 2;
        else if (m_cnt < DW[m_ph] - TOL_M && m_first == 0) code = 3;
        else begin
          m_ph = idx; m_cnt = 1; m_first = 0;
        end
        if (code != 0) begin
          m_mode = 2; m_fault = 1; m_code = code; m_fst = m_ph; m_age = 0; m_safe = 'h111;
        end else m_safe = l;
      end else begin
        if (fault_clr) begin
          m_mode = 0; m_fault = 0; m_code = 0; m_ph = 7; m_safe = l;
        end else begin
          m_age++;
          m_safe = ((m_age / HALF) % 2 == 0) ? 'h111 : 'h000;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("fault", int'(fault), m_fault);
    chk("fault_code", int'(fault_code), m_code);
    chk("fault_state", int'(fault_state), m_fst);
    chk("phase", int'(phase), (m_mode == 0) ? 7 : m_ph);
    chk("safe_lights", int'(safe_lights), m_safe);
  end

  task automatic hold(input logic [11:0] p, input int n, input logic clr = 1'b0);
    repeat (n) begin
      @(negedge clk);
      lights    = p;
      fault_clr = clr;
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fault();
    hold(12'h111, 3);
    hold(12'h111, 1, 1'b1);
    hold(12'h111, 2);
  endtask

  initial begin
    rst = 1'b1; lights = 12'h111; fault_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("lit_rst_fault", int'(fault), 0);
    chk("lit_rst_phase", int'(phase), 7);
    chk("lit_rst_safe", int'(safe_lights), 'h111);
    @(negedge clk);
    rst = 1'b0;

    // 1: full legal loop, stopping mid-S2
    hold(12'hA38, 64); hold(12'h458, 4); hold(12'h893, 16); hold(12'h854, 4);
    hold(12'h38A, 20); hold(12'h886, 4); hold(12'hA38, 64); hold(12'h458, 4);
    hold(12'h893, 8);
    settle();
    chk("lit_loop_phase", int'(phase), 2);
    chk("lit_loop_safe", int'(safe_lights), 'h893);

    // 2: illegal pattern mid-S2, then watch the flash
    hold(12'hFFF, 1);
    settle();
    chk("lit_ill_code", int'(fault_code), 1);
    chk("lit_ill_state", int'(fault_state), 2);
    chk("lit_ill_safe", int'(safe_lights), 'h111);
    hold(12'hA38, 40);
    clear_fault();

    // 3: S2 followed by S4 is out of sequence
    hold(12'hA38, 3); hold(12'h458, 4); hold(12'h893, 16); hold(12'h38A, 1);
    settle();
    chk("lit_seq_code", int'(fault_code), 2);
    chk("lit_seq_state", int'(fault_state), 2);
    clear_fault();

    // 4: S1 held 3 after an accepted S0 is too short; 4 is exact
    hold(12'h886, 2); hold(12'hA38, 64); hold(12'h458, 3); hold(12'h893, 1);
    settle();
    chk("lit_short_code", int'(fault_code), 3);
    chk("lit_short_state", int'(fault_state), 1);
    clear_fault();
    hold(12'h886, 2); hold(12'hA38, 64); hold(12'h458, 4); hold(12'h893, 5);
    settle();
    chk("lit_exact_fault", int'(fault), 0);

    // 5: S3 held exactly 4 passes; then via S6 branch, S3 held 5 is stuck
    hold(12'h893, 11); hold(12'h854, 4); hold(12'h38A, 20); hold(12'h886, 4);
    hold(12'hA38, 64); hold(12'h648, 4); hold(12'h38A, 20); hold(12'h886, 4);
    hold(12'hA38, 64); hold(12'h458, 4); hold(12'h893, 16); hold(12'h854, 5);
    settle();
    chk("lit_stuck_code", int'(fault_code), 4);
    chk("lit_stuck_state", int'(fault_state), 3);

    // 6: clear, resume mid-S4, then clr+violation together, then reset mid-flash
    hold(12'h854, 3);
    hold(12'h38A, 1, 1'b1);
    hold(12'h38A, 7); hold(12'h886, 4); hold(12'hA38, 10);
    settle();
    chk("lit_resume_fault", int'(fault), 0);
    chk("lit_resume_phase", int'(phase), 0);
    hold(12'hFFF, 1, 1'b1);
    settle();
    chk("lit_clr_vs_viol", int'(fault_code), 1);
    hold(12'hA38, 11);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("lit_midflash_fault", int'(fault), 0);
    chk("lit_midflash_safe", int'(safe_lights), 'h111);
    chk("lit_midflash_phase", int'(phase), 7);
    hold(12'hA38, 3);
    @(negedge clk);
    rst = 1'b0;
    hold(12'hA38, 5);
    settle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
